game_sequencer: RTL and testbench

//  Top-level sequencer for the rhythm game datapath. Conditions the raw start, pause and hit inputs.

---
 rtl/game_sequencer.sv | 154 +++++++++++++++
 tb/tb_game_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Rhythm-game sequencer: input conditioning, beat divider and the
// IDLE/COUNTDOWN/PLAYING/PAUSED/DONE control flow for the datapath.
module game_sequencer #(
  parameter int unsigned CLK_DIV         = 6250000,
  parameter int unsigned MAP_LEN         = 191,
  parameter int unsigned COUNTDOWN_BEATS = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_n,
  input  logic       pause_n,
  input  logic       hit_n,
  output logic       load_map,
  output logic       shift_en,
  output logic       beat_tick,
  output logic       hit_pulse,
  output logic [2:0] state,
  output logic [7:0] beats_left,
  output logic       game_over
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]       MAP_BEATS = 8'(MAP_LEN);
  localparam logic [7:0]       CD_BEATS  = 8'(COUNTDOWN_BEATS);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAYING   = 3'd2,
    S_PAUSED    = 3'd3,
    S_DONE      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       beats_q, beats_d, beats_dec;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       start_sync_q, pause_sync_q;
  logic [1:0]       hit_sync_q;
  logic             start_press_q, pause_press_q;
  logic             hit_acc_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic             hit_diff, hit_update, tick;

  // Bit [1] is the synchronized level, bit [2] its previous value for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q  <= '1;
      pause_sync_q  <= '1;
      hit_sync_q    <= '1;
      start_press_q <= 1'b0;
      pause_press_q <= 1'b0;
    end else begin
      start_sync_q  <= {start_sync_q[1:0], start_n};
      pause_sync_q  <= {pause_sync_q[1:0], pause_n};
      hit_sync_q    <= {hit_sync_q[0], hit_n};
      start_press_q <= start_sync_q[2] & ~start_sync_q[1];
      pause_press_q <= pause_sync_q[2] & ~pause_sync_q[1];
    end
  end

  assign hit_diff   = hit_sync_q[1] != hit_acc_q;
  assign hit_update = hit_diff && (db_cnt_q == DB_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q  <= '0;
      hit_acc_q <= 1'b1;
    end else begin
      if (!hit_diff || hit_update) db_cnt_q <= '0;
      else                         db_cnt_q <= db_cnt_q + 1'b1;
      if (hit_update) hit_acc_q <= hit_sync_q[1];
    end
  end

  assign tick      = ((state_q == S_COUNTDOWN) || (state_q == S_PLAYING)) && (div_q == DIV_LAST);
  assign beats_dec = (beats_q != 8'd0) ? beats_q - 8'd1 : 8'd0;

  // Priority within one cycle: start press, then beat tick, then pause press.
  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    div_d    = '0;
    load_map = 1'b0;
    case (state_q)
      S_COUNTDOWN, S_PLAYING: div_d = tick ? '0 : div_q + 1'b1;
      S_PAUSED:               div_d = div_q;
      default:                div_d = '0;
    endcase
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_press_q) begin
          state_d  = S_COUNTDOWN;
          beats_d  = CD_BEATS;
          load_map = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (start_press_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (beats_q == 8'd1) begin
            state_d = S_PLAYING;
            beats_d = MAP_BEATS;
          end else begin
            beats_d = beats_dec;
          end
        end
      end
      S_PLAYING: begin
        if (start_press_q) begin
          state_d = S_IDLE;
        end else if (tick) begin
          if (beats_q == 8'd1) begin
            state_d = S_DONE;
            beats_d = 8'd0;
          end else begin
            beats_d = beats_dec;
          end
        end else if (pause_press_q) begin
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (start_press_q)      state_d = S_IDLE;
        else if (pause_press_q) state_d = S_PLAYING;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beats_q <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      div_q   <= div_d;
    end
  end

  assign beat_tick  = tick;
  assign hit_pulse  = hit_update && !hit_sync_q[1] && (state_q == S_PLAYING);
  assign shift_en   = state_q == S_PLAYING;
  assign game_over  = state_q == S_DONE;
  assign state      = state_q;
  assign beats_left = beats_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small timing parameters.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_n = 1'b1;
  logic       pause_n = 1'b1;
  logic       hit_n = 1'b1;
  logic       load_map, shift_en, beat_tick, hit_pulse, game_over;
  logic [2:0] state;
  logic [7:0] beats_left;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int tick_cnt = 0;
  int hit_cnt = 0;
  int t0, h0, l0;

  game_sequencer #(
    .CLK_DIV(4),
    .MAP_LEN(5),
    .COUNTDOWN_BEATS(2),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start_n(start_n),
    .pause_n(pause_n),
    .hit_n(hit_n),
    .load_map(load_map),
    .shift_en(shift_en),
    .beat_tick(beat_tick),
    .hit_pulse(hit_pulse),
    .state(state),
    .beats_left(beats_left),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load_map)  load_cnt++;
    if (beat_tick) tick_cnt++;
    if (hit_pulse) hit_cnt++;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_start();
    start_n = 1'b0;
    cyc(1);
    start_n = 1'b1;
  endtask

  task automatic press_pause();
    pause_n = 1'b0;
    cyc(1);
    pause_n = 1'b1;
  endtask

  task automatic hit_seq();
    hit_n = 1'b0; cyc(1);
    hit_n = 1'b1; cyc(1);
    hit_n = 1'b0; cyc(10);
    hit_n = 1'b1; cyc(8);
  endtask

  task automatic wait_state(input int exp, input int max_cyc, input string tag);
    int n = 0;
    while (state != 3'(exp) && n < max_cyc) begin
      cyc(1);
      n++;
    end
    check_eq(tag, int'(state), exp);
  endtask

  task automatic wait_tick(input int b, input int max_cyc, input string tag);
    int n = 0;
    while (!(beat_tick && beats_left == 8'(b) && state == 3'd2) && n < max_cyc) begin
      cyc(1);
      n++;
    end
    check_eq(tag, int'(beat_tick && beats_left == 8'(b)), 1);
  endtask

  initial begin
    #2;
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_beats", int'(beats_left), 0);
    check_eq("rst_over", int'(game_over), 0);
    #20 rst = 1'b0;
    cyc(20);
    check_eq("idle_state", int'(state), 0);
    check_eq("idle_ticks", tick_cnt, 0);
    check_eq("idle_loads", load_cnt, 0);
    check_eq("idle_shift", int'(shift_en), 0);
    check_eq("idle_hits", hit_cnt, 0);

    // Game 1: full run, exact cycle timing.
    press_start();
    cyc(3);
    check_eq("g1_cd_state", int'(state), 1);
    check_eq("g1_cd_beats", int'(beats_left), 2);
    check_eq("g1_one_load", load_cnt, 1);
    cyc(8);
    check_eq("g1_play_state", int'(state), 2);
    check_eq("g1_play_beats", int'(beats_left), 5);
    check_eq("g1_play_shift", int'(shift_en), 1);
    check_eq("g1_cd_ticks", tick_cnt, 2);
    cyc(20);
    check_eq("g1_done_state", int'(state), 4);
    check_eq("g1_done_over", int'(game_over), 1);
    check_eq("g1_done_beats", int'(beats_left), 0);
    check_eq("g1_done_shift", int'(shift_en), 0);
    check_eq("g1_total_ticks", tick_cnt, 7);

    // Game 2: replay, pause/resume, hits ignored while paused.
    press_start();
    cyc(3);
    check_eq("g2_replay_load", load_cnt, 2);
    check_eq("g2_replay_beats", int'(beats_left), 2);
    wait_state(2, 20, "g2_to_play");
    wait_tick(4, 20, "g2_tick_b4");
    press_pause();
    cyc(3);
    check_eq("g2_paused_state", int'(state), 3);
    check_eq("g2_paused_beats", int'(beats_left), 3);
    t0 = tick_cnt;
    cyc(50);
    check_eq("g2_pause_ticks", tick_cnt - t0, 0);
    check_eq("g2_pause_hold", int'(beats_left), 3);
    check_eq("g2_pause_shift", int'(shift_en), 0);
    h0 = hit_cnt;
    hit_seq();
    check_eq("g2_pause_hits", hit_cnt - h0, 0);
    press_pause();
    cyc(3);
    check_eq("g2_resume_state", int'(state), 2);
    t0 = tick_cnt;
    cyc(4);
    check_eq("g2_resume_tick", tick_cnt - t0, 1);
    check_eq("g2_resume_beats", int'(beats_left), 2);
    wait_state(4, 40, "g2_done");

    // Game 3: debounced hit while playing.
    press_start();
    wait_state(2, 30, "g3_to_play");
    h0 = hit_cnt;
    hit_seq();
    check_eq("g3_one_hit", hit_cnt - h0, 1);
    wait_state(4, 40, "g3_done");

    // Game 4: start press colliding with a beat tick.
    press_start();
    wait_state(2, 30, "g4_to_play");
    wait_tick(4, 20, "g4_tick_b4");
    cyc(1);
    press_start();
    cyc(2);
    check_eq("g4_coll_tick", int'(beat_tick), 1);
    check_eq("g4_coll_pre", int'(beats_left), 3);
    cyc(1);
    check_eq("g4_abort_state", int'(state), 0);
    check_eq("g4_abort_beats", int'(beats_left), 3);
    check_eq("g4_abort_shift", int'(shift_en), 0);

    // Game 5: asynchronous reset mid-play, then a fresh start.
    press_start();
    wait_state(2, 30, "g5_to_play");
    cyc(2);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_state", int'(state), 0);
    check_eq("arst_shift", int'(shift_en), 0);
    check_eq("arst_beats", int'(beats_left), 0);
    check_eq("arst_pulses", int'({load_map, beat_tick, hit_pulse, game_over}), 0);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    l0 = load_cnt;
    press_start();
    cyc(3);
    check_eq("post_rst_load", load_cnt - l0, 1);
    check_eq("post_rst_state", int'(state), 1);
    check_eq("post_rst_beats", int'(beats_left), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
